// File: rtl/aes_avalon_pkg.sv
// -----------------------------------------------------------------------------
// aes_avalon_pkg
// Shared types, register-map addresses and small helpers for the AES
// Avalon-MM responder.
//   fsm_t         : handshake FSM states
//   word_t        : 32-bit register word
//   ADDR_*        : register word addresses
//   apply_be      : byte-lane merge of a write into an existing word
//   bus_writable  : which addresses the bus may write, given the FSM state
// -----------------------------------------------------------------------------
package aes_avalon_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE_ST
    } fsm_t;

    typedef logic [31:0] word_t;

    localparam logic [3:0] ADDR_KEY0    = 4'd0;
    localparam logic [3:0] ADDR_KEY1    = 4'd1;
    localparam logic [3:0] ADDR_KEY2    = 4'd2;
    localparam logic [3:0] ADDR_KEY3    = 4'd3;
    localparam logic [3:0] ADDR_MSG_EN0 = 4'd4;
    localparam logic [3:0] ADDR_MSG_EN1 = 4'd5;
    localparam logic [3:0] ADDR_MSG_EN2 = 4'd6;
    localparam logic [3:0] ADDR_MSG_EN3 = 4'd7;
    localparam logic [3:0] ADDR_MSG_DE0 = 4'd8;
    localparam logic [3:0] ADDR_MSG_DE1 = 4'd9;
    localparam logic [3:0] ADDR_MSG_DE2 = 4'd10;
    localparam logic [3:0] ADDR_MSG_DE3 = 4'd11;
    localparam logic [3:0] ADDR_CYCLES  = 4'd12;
    localparam logic [3:0] ADDR_RSVD    = 4'd13;
    localparam logic [3:0] ADDR_START   = 4'd14;
    localparam logic [3:0] ADDR_DONE    = 4'd15;

    function automatic word_t apply_be(word_t old_w, word_t new_w, logic [3:0] be);
        word_t res;
        res = old_w;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
                res[b*8 +: 8] = new_w[b*8 +: 8];
            end
        end
        return res;
    endfunction

    // KEY and MSG_EN are frozen while the core is working on them; START is
    // always writable; everything else is owned by the engine or unused.
    function automatic logic bus_writable(logic [3:0] addr, logic busy);
        if (addr inside {[ADDR_KEY0:ADDR_MSG_EN3]}) begin
            return !busy;
        end
        return addr == ADDR_START;
    endfunction

endpackage

// File: rtl/aes_reg_file.sv
// -----------------------------------------------------------------------------
// aes_reg_file
// 16x32 storage behind the Avalon responder. Bus writes are byte-lane gated
// and filtered by a per-address write mask; the MSG_DE words are loaded only
// from the engine result port.
// Ports:
//   clk, reset_n     : clock, synchronous active-low reset
//   i_wr_en          : bus write strobe (chipselect & write)
//   i_addr, i_be     : word address, byte enables
//   i_wdata          : bus write data
//   i_busy           : FSM is BUSY (locks KEY / MSG_EN)
//   i_de_load        : load i_de_data into MSG_DE0..3
//   i_de_data        : 128-bit plaintext, bits 127:96 go to MSG_DE0
//   o_words          : all stored words (CYCLES/RSVD/DONE slots read as 0)
// -----------------------------------------------------------------------------
module aes_reg_file
    import aes_avalon_pkg::*;
#(
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [3:0]        i_be,
    input  logic [31:0]       i_wdata,
    input  logic              i_busy,
    input  logic              i_de_load,
    input  logic [127:0]      i_de_data,
    output word_t             o_words [2**ADDR_W]
);

    localparam int unsigned Depth = 2**ADDR_W;

    word_t r_mem [Depth];
    logic  w_wr_ok;

    assign w_wr_ok = i_wr_en && bus_writable(i_addr, i_busy);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < Depth; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_wr_ok) begin
                r_mem[i_addr] <= apply_be(r_mem[i_addr], i_wdata, i_be);
            end
            if (i_de_load) begin
                r_mem[ADDR_MSG_DE0] <= i_de_data[127:96];
                r_mem[ADDR_MSG_DE1] <= i_de_data[95:64];
                r_mem[ADDR_MSG_DE2] <= i_de_data[63:32];
                r_mem[ADDR_MSG_DE3] <= i_de_data[31:0];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < Depth; i++) begin
            o_words[i] = r_mem[i];
        end
    end

endmodule

// File: rtl/aes_avalon_slave.sv
// -----------------------------------------------------------------------------
// aes_avalon_slave
// Avalon-MM responder giving the Nios II access to an external AES decrypt
// core: register file, start/done handshake FSM and operation cycle counter.
// Ports:
//   clk, reset_n       : clock, synchronous active-low reset
//   avs_*              : Avalon-MM slave, read latency 1
//   core_start         : one-cycle start pulse to the core
//   core_key, core_msg : {reg0..reg3}, {reg4..reg7}
//   core_done          : core completion (pulse or level)
//   core_result        : plaintext, valid while core_done
//   export_data        : {reg0[31:16], reg3[15:0]} for the hex display
// -----------------------------------------------------------------------------
module aes_avalon_slave
    import aes_avalon_pkg::*;
#(
    parameter int unsigned ADDR_W  = 4,
    parameter logic [31:0] CNT_SAT = 32'hFFFF_FFFF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              avs_chipselect,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic [3:0]        avs_byteenable,
    input  logic [31:0]       avs_writedata,
    output logic [31:0]       avs_readdata,
    output logic              core_start,
    output logic [127:0]      core_key,
    output logic [127:0]      core_msg,
    input  logic              core_done,
    input  logic [127:0]      core_result,
    output logic [31:0]       export_data
);

    fsm_t        r_state;
    fsm_t        w_state_d;
    logic [31:0] r_cycles;
    logic        r_core_start;
    logic [31:0] r_readdata;

    word_t       w_words [2**ADDR_W];
    logic        w_wr;
    logic        w_rd;
    logic        w_start_wr;
    logic        w_start_eff;
    logic        w_start_next;
    logic        w_go;
    logic        w_de_load;
    logic [31:0] w_rdata;

    assign w_wr       = avs_chipselect && avs_write;
    assign w_rd       = avs_chipselect && avs_read;
    assign w_start_wr = w_wr && (avs_address == ADDR_START);
    // Bit0 as it will be after this write, honouring the byte lane.
    assign w_start_eff  = avs_byteenable[0] ? avs_writedata[0] : w_words[ADDR_START][0];
    // Bit0 as it stands next cycle, with or without a write now.
    assign w_start_next = w_start_wr ? w_start_eff : w_words[ADDR_START][0];

    aes_reg_file #(
        .ADDR_W (ADDR_W)
    ) u_reg_file (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_wr_en   (w_wr),
        .i_addr    (avs_address),
        .i_be      (avs_byteenable),
        .i_wdata   (avs_writedata),
        .i_busy    (r_state == BUSY),
        .i_de_load (w_de_load),
        .i_de_data (core_result),
        .o_words   (w_words)
    );

    always_comb begin
        w_state_d = r_state;
        w_go      = 1'b0;
        w_de_load = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start_wr && w_start_eff) begin
                    w_state_d = BUSY;
                    w_go      = 1'b1;
                end
            end
            BUSY: begin
                if (core_done) begin
                    w_state_d = DONE_ST;
                    w_de_load = 1'b1;
                end
            end
            DONE_ST: begin
                // Also exits the cycle after a START=0 write made while BUSY.
                if (!w_start_next) begin
                    w_state_d = IDLE;
                end
            end
            default: w_state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_core_start <= 1'b0;
            r_cycles     <= '0;
        end else begin
            r_state      <= w_state_d;
            r_core_start <= w_go;
            if (w_go) begin
                r_cycles <= '0;
            end else if (r_state == BUSY && !core_done && r_cycles != CNT_SAT) begin
                r_cycles <= r_cycles + 32'd1;
            end
        end
    end

    always_comb begin
        w_rdata = w_words[avs_address];
        case (avs_address)
            ADDR_CYCLES: w_rdata = r_cycles;
            ADDR_RSVD:   w_rdata = '0;
            ADDR_DONE:   w_rdata = {31'd0, r_state == DONE_ST};
            default:     w_rdata = w_words[avs_address];
        endcase
    end

    // Registered from current state, so a same-cycle write is not visible.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_readdata <= '0;
        end else if (w_rd) begin
            r_readdata <= w_rdata;
        end
    end

    assign avs_readdata = r_readdata;
    assign core_start   = r_core_start;
    assign core_key     = {w_words[ADDR_KEY0], w_words[ADDR_KEY1],
                           w_words[ADDR_KEY2], w_words[ADDR_KEY3]};
    assign core_msg     = {w_words[ADDR_MSG_EN0], w_words[ADDR_MSG_EN1],
                           w_words[ADDR_MSG_EN2], w_words[ADDR_MSG_EN3]};
    assign export_data  = {w_words[ADDR_KEY0][31:16], w_words[ADDR_KEY3][15:0]};

endmodule

// File: tb/tb_aes_avalon_slave.sv
// -----------------------------------------------------------------------------
// tb_aes_avalon_slave
// Directed bench for aes_avalon_slave with a behavioural AES core stand-in
// (result = msg ^ key, done 10 cycles after start). Reads push their expected
// word into a queue; a monitor pops and compares when readdata appears.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_aes_avalon_slave;

    logic         clk;
    logic         reset_n;
    logic         avs_chipselect;
    logic         avs_read;
    logic         avs_write;
    logic [3:0]   avs_address;
    logic [3:0]   avs_byteenable;
    logic [31:0]  avs_writedata;
    logic [31:0]  avs_readdata;
    logic         core_start;
    logic [127:0] core_key;
    logic [127:0] core_msg;
    logic         core_done;
    logic [127:0] core_result;
    logic [31:0]  export_data;

    logic         model_done;
    logic         man_done;

    int checks = 0;
    int errors = 0;
    int pulse_cnt = 0;
    int high_cnt = 0;

    logic [31:0] exp_q[$];
    string       name_q[$];

    assign core_done = model_done | man_done;

    aes_avalon_slave #(
        .ADDR_W  (4),
        .CNT_SAT (32'hFFFF_FFFF)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .avs_chipselect (avs_chipselect),
        .avs_read       (avs_read),
        .avs_write      (avs_write),
        .avs_address    (avs_address),
        .avs_byteenable (avs_byteenable),
        .avs_writedata  (avs_writedata),
        .avs_readdata   (avs_readdata),
        .core_start     (core_start),
        .core_key       (core_key),
        .core_msg       (core_msg),
        .core_done      (core_done),
        .core_result    (core_result),
        .export_data    (export_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
        @(negedge clk);
        avs_chipselect = 1'b1;
        avs_write      = 1'b1;
        avs_address    = a;
        avs_byteenable = be;
        avs_writedata  = d;
        @(negedge clk);
        avs_chipselect = 1'b0;
        avs_write      = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, input logic [31:0] e, input string nm);
        @(negedge clk);
        avs_chipselect = 1'b1;
        avs_read       = 1'b1;
        avs_address    = a;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(negedge clk);
        avs_chipselect = 1'b0;
        avs_read       = 1'b0;
    endtask

    // Read monitor: readdata is valid just after the edge that sampled the read.
    initial begin
        forever begin
            @(posedge clk);
            if (avs_chipselect && avs_read && reset_n) begin
                #1;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_read: got %h expected none", avs_readdata);
                end else begin
                    chk(name_q.pop_front(), avs_readdata, exp_q.pop_front());
                end
            end
        end
    end

    // core_start pulse counter (pulses and total high cycles).
    initial begin
        logic prev;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (core_start === 1'b1) begin
                high_cnt++;
                if (!prev) pulse_cnt++;
            end
            prev = (core_start === 1'b1);
        end
    end

    // Core stand-in: done one cycle wide, 10 cycles after the start cycle.
    initial begin
        logic [127:0] k;
        logic [127:0] m;
        logic         abort;
        model_done  = 1'b0;
        core_result = '0;
        forever begin
            @(negedge clk);
            if (core_start === 1'b1 && reset_n) begin
                k = core_key;
                m = core_msg;
                abort = 1'b0;
                for (int i = 0; i < 10; i++) begin
                    @(posedge clk);
                    if (!reset_n) abort = 1'b1;
                end
                if (!abort) begin
                    #1;
                    core_result = m ^ k;
                    model_done  = 1'b1;
                    @(posedge clk);
                    #1;
                    model_done  = 1'b0;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        int h0;
        logic [31:0] de_exp [4];
        de_exp[0] = 32'h00102030;
        de_exp[1] = 32'h40506070;
        de_exp[2] = 32'h8090a0b0;
        de_exp[3] = 32'hc0d0e0f0;

        reset_n        = 1'b0;
        avs_chipselect = 1'b0;
        avs_read       = 1'b0;
        avs_write      = 1'b0;
        avs_address    = '0;
        avs_byteenable = '0;
        avs_writedata  = '0;
        man_done       = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_export", export_data, 32'h0);
        chk("reset_core_start", {31'd0, core_start}, 32'h0);
        chk("reset_readdata", avs_readdata, 32'h0);
        reset_n = 1'b1;
        for (int a = 0; a < 16; a++) begin
            rd(4'(a), 32'h0, $sformatf("reset_reg%0d", a));
        end

        // Read-only / reserved writes ignored in IDLE
        wr(4'd15, 32'h1, 4'hF);
        wr(4'd13, 32'hFFFF_FFFF, 4'hF);
        wr(4'd12, 32'h1234_5678, 4'hF);
        wr(4'd8, 32'h1, 4'hF);
        rd(4'd15, 32'h0, "done_ro_idle");
        rd(4'd13, 32'h0, "rsvd_ro");
        rd(4'd12, 32'h0, "cycles_ro");
        rd(4'd8, 32'h0, "msgde_ro_idle");

        // Byte enables and export conduit
        wr(4'd0, 32'h00010203, 4'hF);
        wr(4'd0, 32'hFFFF_FFFF, 4'b0001);
        rd(4'd0, 32'h000102FF, "key0_be");
        wr(4'd3, 32'h0C0D0E0F, 4'hF);
        @(negedge clk);
        chk("export_data", export_data, 32'h00010E0F);

        // Setup
        wr(4'd0, 32'h00010203, 4'hF);
        wr(4'd1, 32'h04050607, 4'hF);
        wr(4'd2, 32'h08090a0b, 4'hF);
        wr(4'd4, 32'h00112233, 4'hF);
        wr(4'd5, 32'h44556677, 4'hF);
        wr(4'd6, 32'h8899aabb, 4'hF);
        wr(4'd7, 32'hccddeeff, 4'hF);
        rd(4'd7, 32'hccddeeff, "msgen3");

        // Full run with writes attempted while BUSY
        p0 = pulse_cnt;
        h0 = high_cnt;
        wr(4'd14, 32'h1, 4'hF);
        wr(4'd0, 32'hDEADBEEF, 4'hF);
        wr(4'd8, 32'h1, 4'hF);
        rd(4'd8, 32'h0, "msgde0_busy_protect");
        rd(4'd0, 32'h00010203, "key0_busy_protect");
        rd(4'd15, 32'h0, "done_while_busy");
        repeat (15) @(negedge clk);
        chk("run1_pulses", 32'(pulse_cnt - p0), 32'd1);
        chk("run1_high_cycles", 32'(high_cnt - h0), 32'd1);
        rd(4'd15, 32'h1, "run1_done");
        for (int i = 0; i < 4; i++) begin
            rd(4'(8 + i), de_exp[i], $sformatf("run1_msgde%0d", i));
        end
        rd(4'd12, 32'd10, "run1_cycles");

        // DONE_ST: rewrite START=1 -> no restart
        p0 = pulse_cnt;
        wr(4'd14, 32'h1, 4'hF);
        repeat (15) @(negedge clk);
        chk("donest_no_restart", 32'(pulse_cnt - p0), 32'd0);
        rd(4'd15, 32'h1, "done_held");

        // START=0 clears DONE; a new START gives one pulse
        wr(4'd14, 32'h0, 4'hF);
        rd(4'd15, 32'h0, "done_cleared");
        p0 = pulse_cnt;
        wr(4'd14, 32'h1, 4'hF);
        repeat (15) @(negedge clk);
        chk("run2_pulses", 32'(pulse_cnt - p0), 32'd1);
        rd(4'd15, 32'h1, "run2_done");
        rd(4'd12, 32'd10, "run2_cycles");
        rd(4'd11, de_exp[3], "run2_msgde3");

        // START=0 during BUSY: completes, then drops to IDLE by itself
        wr(4'd14, 32'h0, 4'hF);
        p0 = pulse_cnt;
        wr(4'd14, 32'h1, 4'hF);
        wr(4'd14, 32'h0, 4'hF);
        repeat (15) @(negedge clk);
        chk("run3_pulses", 32'(pulse_cnt - p0), 32'd1);
        rd(4'd15, 32'h0, "run3_done_autoclear");
        rd(4'd14, 32'h0, "run3_start");
        rd(4'd8, de_exp[0], "run3_msgde0");

        // Reset mid-BUSY, then a stray core_done
        p0 = pulse_cnt;
        wr(4'd14, 32'h1, 4'hF);
        repeat (5) @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        man_done = 1'b1;
        @(negedge clk);
        man_done = 1'b0;
        repeat (15) @(negedge clk);
        chk("rst_mid_pulses", 32'(pulse_cnt - p0), 32'd1);
        chk("rst_mid_export", export_data, 32'h0);
        rd(4'd15, 32'h0, "rst_mid_done");
        for (int i = 0; i < 4; i++) begin
            rd(4'(8 + i), 32'h0, $sformatf("rst_mid_msgde%0d", i));
        end
        rd(4'd12, 32'h0, "rst_mid_cycles");
        rd(4'd0, 32'h0, "rst_mid_key0");

        // Back in IDLE: a new START still works
        p0 = pulse_cnt;
        wr(4'd14, 32'h1, 4'hF);
        repeat (15) @(negedge clk);
        chk("post_rst_pulses", 32'(pulse_cnt - p0), 32'd1);
        rd(4'd15, 32'h1, "post_rst_done");

        repeat (4) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
